// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Steps one digit per slot, drives the active-low anode and decimal point, and
// double-buffers new values so they only take effect at a frame boundary.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              digit_hex,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  typedef struct packed {
    logic [VAL_W-1:0]      val;
    logic [NUM_DIGITS-1:0] dp;
    logic                  lz;
  } snap_t;

  snap_t            active_q;
  snap_t            pending_q;
  snap_t            load_snap;
  logic             pend_v_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             slot_end;
  logic             frame_end;
  logic [NUM_DIGITS:0] zero_sfx;
  logic             blank;
  logic             lit;

  assign load_snap = '{val: value, dp: dp_in, lz: blank_lz};
  assign slot_end  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Slot/digit counters and the pending -> active snapshot hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= frame_end ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (load) begin
        pending_q <= load_snap;
      end

      // A load on the boundary cycle bypasses pending so it is shown immediately.
      if (frame_end) begin
        pend_v_q <= 1'b0;
        if (load) begin
          active_q <= load_snap;
        end else if (pend_v_q) begin
          active_q <= pending_q;
        end
      end else if (load) begin
        pend_v_q <= 1'b1;
      end
    end
  end

  // zero_sfx[i]: digits i..N-1 have zero nibbles and no decimal point.
  always_comb begin
    zero_sfx             = '0;
    zero_sfx[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_sfx[i] = zero_sfx[i+1] && (active_q.val[4*i +: 4] == 4'h0) && !active_q.dp[i];
    end
  end

  // Digit 0 is never blanked so an all-zero value still shows "0".
  assign blank = active_q.lz && (idx_q != '0) && zero_sfx[idx_q];
  assign lit   = (cnt_q >= CNT_W'(GUARD)) && !blank;

  // Display outputs decoded from registered scan state.
  always_comb begin
    an_n      = '1;
    dp_n      = 1'b1;
    digit_hex = active_q.val[4*idx_q +: 4];
    if (lit) begin
      an_n[idx_q] = 1'b0;
      dp_n        = ~active_q.dp[idx_q];
    end
  end

  assign frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 8-cycle slots, 2-cycle guard,
// plus a second instance with no guard and 2-cycle slots.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        load2 = 1'b0;
  logic [15:0] value = '0;
  logic [15:0] value2 = 16'h4321;
  logic [3:0]  dp_in = '0;
  logic [3:0]  dp_zero = '0;
  logic        blank_lz = 1'b0;
  logic        lz_zero = 1'b0;

  logic [3:0]  digit_hex, digit_hex2;
  logic [3:0]  an_n, an_n2;
  logic        dp_n, dp_n2;
  logic        frame_done, frame_done2;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .digit_hex(digit_hex), .an_n(an_n), .dp_n(dp_n),
    .frame_done(frame_done)
  );

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(2), .GUARD(0)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .value(value2), .dp_in(dp_zero),
    .blank_lz(lz_zero), .digit_hex(digit_hex2), .an_n(an_n2), .dp_n(dp_n2),
    .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s @cyc%0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    value    = v;
    dp_in    = dp;
    blank_lz = lz;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic slot(input string tag, input logic [3:0] hex, input logic [3:0] an, input logic dp);
    check({tag, "_hex"}, 16'(digit_hex), 16'(hex));
    check({tag, "_an"},  16'(an_n), 16'(an));
    check({tag, "_dp"},  16'(dp_n), 16'(dp));
  endtask

  // At most one anode may be enabled on any cycle, for both instances.
  always @(negedge clk) begin
    check("onehot_an", 16'($countones(~an_n) <= 1), 16'd1);
    check("onehot_an2", 16'($countones(~an_n2) <= 1), 16'd1);
  end

  initial begin
    // 1: reset state, guard window and frame_done period
    do_reset();
    for (int c = 0; c < 64; c++) begin
      goto(c);
      if (c < 2) slot("t1_guard", 4'h0, 4'b1111, 1'b1);
      else if (c < 8) slot("t1_slot0", 4'h0, 4'b1110, 1'b1);
      check("t1_fd", 16'(frame_done), 16'((c % 32) == 31));
    end

    // 2: load mid-frame is deferred to the next frame
    do_reset();
    goto(5);
    do_load(16'h12AB, 4'b0001, 1'b0);
    goto(10); slot("t2_f0", 4'h0, 4'b1101, 1'b1);
    goto(32); slot("t2_guard", 4'hB, 4'b1111, 1'b1);
    goto(34); slot("t2_d0", 4'hB, 4'b1110, 1'b0);
    goto(42); slot("t2_d1", 4'hA, 4'b1101, 1'b1);
    goto(50); slot("t2_d2", 4'h2, 4'b1011, 1'b1);
    goto(58); slot("t2_d3", 4'h1, 4'b0111, 1'b1);

    // 3: leading-zero suppression
    do_reset();
    do_load(16'h0005, 4'b0000, 1'b1);
    goto(34); slot("t3a_d0", 4'h5, 4'b1110, 1'b1);
    goto(42); slot("t3a_d1", 4'h0, 4'b1111, 1'b1);
    goto(50); slot("t3a_d2", 4'h0, 4'b1111, 1'b1);
    goto(58); slot("t3a_d3", 4'h0, 4'b1111, 1'b1);
    goto(60);
    do_load(16'h0000, 4'b0000, 1'b1);
    goto(66); slot("t3b_d0", 4'h0, 4'b1110, 1'b1);
    goto(74); slot("t3b_d1", 4'h0, 4'b1111, 1'b1);
    goto(80);
    do_load(16'h0005, 4'b0100, 1'b1);
    goto(98);  slot("t3c_d0", 4'h5, 4'b1110, 1'b1);
    goto(106); slot("t3c_d1", 4'h0, 4'b1101, 1'b1);
    goto(114); slot("t3c_d2", 4'h0, 4'b1011, 1'b0);
    goto(122); slot("t3c_d3", 4'h0, 4'b1111, 1'b1);

    // 4: latest pending wins; load on the boundary cycle is shown at once
    do_reset();
    goto(3);  do_load(16'h1111, 4'b0000, 1'b0);
    goto(10); do_load(16'h2222, 4'b0000, 1'b0);
    goto(20); do_load(16'h3333, 4'b0000, 1'b0);
    goto(26); slot("t4_f0", 4'h0, 4'b0111, 1'b1);
    goto(34); slot("t4_d0", 4'h3, 4'b1110, 1'b1);
    goto(42); slot("t4_d1", 4'h3, 4'b1101, 1'b1);
    goto(50); do_load(16'h5555, 4'b0000, 1'b0);
    goto(63);
    check("t4_fd", 16'(frame_done), 16'd1);
    do_load(16'h4444, 4'b0000, 1'b0);
    slot("t4_bguard", 4'h4, 4'b1111, 1'b1);
    goto(66); slot("t4_b0", 4'h4, 4'b1110, 1'b1);
    goto(98); slot("t4_b1", 4'h4, 4'b1110, 1'b1);

    // 5: reset mid-frame discards active and pending
    do_reset();
    do_load(16'h9999, 4'b0000, 1'b0);
    goto(40); do_load(16'h7777, 4'b0000, 1'b0);
    goto(53); slot("t5_pre", 4'h9, 4'b1011, 1'b1);
    do_reset();
    slot("t5_rst", 4'h0, 4'b1111, 1'b1);
    check("t5_fd", 16'(frame_done), 16'd0);
    goto(34); slot("t5_d0", 4'h0, 4'b1110, 1'b1);
    goto(42); slot("t5_d1", 4'h0, 4'b1101, 1'b1);

    // 6: no guard, 2-cycle slots
    do_reset();
    check("t6_rst_an", 16'(an_n2), 16'b1110);
    check("t6_rst_hex", 16'(digit_hex2), 16'h0);
    load2 = 1'b1;
    step();
    load2 = 1'b0;
    goto(6); check("t6_fd_lo", 16'(frame_done2), 16'd0);
    goto(7); check("t6_fd_hi", 16'(frame_done2), 16'd1);
    goto(8);
    check("t6_d0_an", 16'(an_n2), 16'b1110);
    check("t6_d0_hex", 16'(digit_hex2), 16'h1);
    goto(9);  check("t6_d0b_an", 16'(an_n2), 16'b1110);
    goto(10);
    check("t6_d1_an", 16'(an_n2), 16'b1101);
    check("t6_d1_hex", 16'(digit_hex2), 16'h2);
    goto(14);
    check("t6_d3_an", 16'(an_n2), 16'b0111);
    check("t6_d3_hex", 16'(digit_hex2), 16'h4);
    check("t6_dp", 16'(dp_n2), 16'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
